// File: rtl/score_pkg.sv
// Shared types and constants for the BCD score keeper.
package score_pkg;

    localparam int unsigned NUM_DIGITS = 5;

    typedef logic [3:0] bcd_t;
    typedef bcd_t [NUM_DIGITS-1:0] score_t;

    localparam score_t SCORE_MAX = {NUM_DIGITS{4'd9}};

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StCommit
    } state_e;

    // Amount codes 10..15 are not valid BCD; they count as 9.
    function automatic bcd_t clamp_bcd(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

endpackage

// File: rtl/score_keeper_bcd_digit_add.sv
// Single-digit BCD adder: sum = (a + b + cin) mod 10, cout when the raw sum exceeds 9.
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    import score_pkg::*;

    logic [4:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        if (raw > 5'd9) begin
            sum  = 4'(raw - 5'd10);
            cout = 1'b1;
        end else begin
            sum  = raw[3:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// BCD score register with a digit-serial adder, atomic commit and a frame-stable display copy.
module score_keeper #(
    parameter int unsigned NUM_DIGITS = 5,
    parameter bit          SATURATE   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    add_valid,
    input  logic [3:0]              add_amount,
    output logic                    add_ready,
    input  logic                    clear,
    input  logic                    frame_start,
    output logic [4*NUM_DIGITS-1:0] disp_digits,
    output logic [4*NUM_DIGITS-1:0] score_digits,
    output logic                    overflow
);
    import score_pkg::*;

    localparam int unsigned    IdxW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

    typedef bcd_t [NUM_DIGITS-1:0] digits_t;

    state_e          state_q, state_d;
    digits_t         score_q, score_d;
    digits_t         work_q, work_d;
    digits_t         disp_q, disp_d;
    bcd_t            carry_q, carry_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            overflow_q, overflow_d;
    logic            ready_q, ready_d;

    bcd_t add_a;
    bcd_t add_sum;
    logic add_cout;

    assign add_a = work_q[idx_q];

    // carry_q holds the whole amount for digit 0 and a 0/1 carry afterwards.
    bcd_digit_add u_digit_add (
        .a    (add_a),
        .b    (carry_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        work_d     = work_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;
        ready_d    = ready_q;
        // Display only ever copies the committed score, so no partial sum is shown.
        disp_d     = frame_start ? score_q : disp_q;

        if (clear) begin
            state_d    = StIdle;
            score_d    = '0;
            work_d     = '0;
            carry_d    = '0;
            idx_d      = '0;
            overflow_d = 1'b0;
            ready_d    = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (add_valid && ready_q) begin
                        work_d  = score_q;
                        carry_d = clamp_bcd(add_amount);
                        idx_d   = '0;
                        state_d = StAdd;
                        ready_d = 1'b0;
                    end
                end
                StAdd: begin
                    work_d[idx_q] = add_sum;
                    carry_d       = {3'b000, add_cout};
                    if (idx_q == LastIdx) begin
                        state_d = StCommit;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                StCommit: begin
                    if (carry_q[0]) begin
                        overflow_d = 1'b1;
                        score_d    = SATURATE ? {NUM_DIGITS{4'd9}} : work_q;
                    end else begin
                        score_d = work_q;
                    end
                    state_d = StIdle;
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            score_q    <= '0;
            work_q     <= '0;
            disp_q     <= '0;
            carry_q    <= '0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            work_q     <= work_d;
            disp_q     <= disp_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            ready_q    <= ready_d;
        end
    end

    assign add_ready    = ready_q;
    assign overflow     = overflow_q;
    assign score_digits = score_q;
    assign disp_digits  = disp_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: 5- and 2-digit instances, each saturating and wrapping, on shared stimulus.
module tb_score_keeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       add_valid;
    logic [3:0] add_amount;
    logic       clear;
    logic       frame_start;

    logic [19:0] sc5s, sc5w, dp5s, dp5w;
    logic [7:0]  sc2s, sc2w, dp2s, dp2w;
    logic        ov5s, ov5w, ov2s, ov2w;
    logic        rd5s, rd5w, rd2s, rd2w;

    always #5 clk = ~clk;

    score_keeper #(.NUM_DIGITS(5), .SATURATE(1'b1)) u_d5s (
        .clk(clk), .rst_n(rst_n), .add_valid(add_valid), .add_amount(add_amount),
        .add_ready(rd5s), .clear(clear), .frame_start(frame_start),
        .disp_digits(dp5s), .score_digits(sc5s), .overflow(ov5s));
    score_keeper #(.NUM_DIGITS(5), .SATURATE(1'b0)) u_d5w (
        .clk(clk), .rst_n(rst_n), .add_valid(add_valid), .add_amount(add_amount),
        .add_ready(rd5w), .clear(clear), .frame_start(frame_start),
        .disp_digits(dp5w), .score_digits(sc5w), .overflow(ov5w));
    score_keeper #(.NUM_DIGITS(2), .SATURATE(1'b1)) u_d2s (
        .clk(clk), .rst_n(rst_n), .add_valid(add_valid), .add_amount(add_amount),
        .add_ready(rd2s), .clear(clear), .frame_start(frame_start),
        .disp_digits(dp2s), .score_digits(sc2s), .overflow(ov2s));
    score_keeper #(.NUM_DIGITS(2), .SATURATE(1'b0)) u_d2w (
        .clk(clk), .rst_n(rst_n), .add_valid(add_valid), .add_amount(add_amount),
        .add_ready(rd2w), .clear(clear), .frame_start(frame_start),
        .disp_digits(dp2w), .score_digits(sc2w), .overflow(ov2w));

    logic [19:0] score_act [4];
    logic [19:0] disp_act  [4];
    logic        ovf_act   [4];
    logic        rdy_act   [4];

    always_comb begin
        score_act[0] = sc5s;          score_act[1] = sc5w;
        score_act[2] = {12'd0, sc2s}; score_act[3] = {12'd0, sc2w};
        disp_act[0]  = dp5s;          disp_act[1]  = dp5w;
        disp_act[2]  = {12'd0, dp2s}; disp_act[3]  = {12'd0, dp2w};
        ovf_act[0] = ov5s; ovf_act[1] = ov5w; ovf_act[2] = ov2s; ovf_act[3] = ov2w;
        rdy_act[0] = rd5s; rdy_act[1] = rd5w; rdy_act[2] = rd2s; rdy_act[3] = rd2w;
    end

    // Reference model: plain integers, one entry per instance.
    int mscore [4];
    int mdisp  [4];
    bit movf   [4];
    int mmax   [4] = '{99999, 99999, 99, 99};
    bit msat   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int mlat   [4] = '{6, 6, 3, 3};
    int lat    [4];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  amt;
        logic [19:0] exp5;
        logic [7:0]  exp2s;
        logic [7:0]  exp2w;
        logic        ov2s;
        logic        ov2w;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int t;
        t = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s score[%0d]", tag, i), 32'(score_act[i]), 32'(to_bcd(mscore[i])));
            check($sformatf("%s disp[%0d]", tag, i), 32'(disp_act[i]), 32'(to_bcd(mdisp[i])));
            check($sformatf("%s ovf[%0d]", tag, i), 32'(ovf_act[i]), 32'(movf[i]));
            check($sformatf("%s ready[%0d]", tag, i), 32'(rdy_act[i]), 32'd1);
        end
    endtask

    function automatic bit all_ready();
        return rdy_act[0] && rdy_act[1] && rdy_act[2] && rdy_act[3];
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!all_ready() && n < 100) begin
            for (int i = 0; i < 4; i++) if (!rdy_act[i]) lat[i]++;
            @(negedge clk);
            n++;
        end
        if (n >= 100) check({tag, " ready timeout"}, 32'd0, 32'd1);
    endtask

    task automatic model_add(input logic [3:0] amt);
        int eff;
        int s;
        eff = (amt > 4'd9) ? 9 : int'(amt);
        for (int i = 0; i < 4; i++) begin
            s = mscore[i] + eff;
            if (s > mmax[i]) begin
                movf[i]   = 1'b1;
                mscore[i] = msat[i] ? mmax[i] : s - (mmax[i] + 1);
            end else begin
                mscore[i] = s;
            end
        end
    endtask

    task automatic add_req(input logic [3:0] amt);
        wait_ready("pre-add");
        add_valid  = 1'b1;
        add_amount = amt;
        @(negedge clk);
        add_valid = 1'b0;
        for (int i = 0; i < 4; i++) lat[i] = 0;
        wait_ready("post-add");
        model_add(amt);
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) mdisp[i] = mscore[i];
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mscore[i] = 0;
            movf[i]   = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mscore[i] = 0;
            mdisp[i]  = 0;
            movf[i]   = 1'b0;
        end
    endtask

    initial begin
        int hs;
        int cyc;
        int op;

        vecs[0]  = '{4'd7,  20'h00007, 8'h07, 8'h07, 1'b0, 1'b0};
        vecs[1]  = '{4'd15, 20'h00016, 8'h16, 8'h16, 1'b0, 1'b0};
        vecs[2]  = '{4'd0,  20'h00016, 8'h16, 8'h16, 1'b0, 1'b0};
        vecs[3]  = '{4'd9,  20'h00025, 8'h25, 8'h25, 1'b0, 1'b0};
        vecs[4]  = '{4'd12, 20'h00034, 8'h34, 8'h34, 1'b0, 1'b0};
        vecs[5]  = '{4'd9,  20'h00043, 8'h43, 8'h43, 1'b0, 1'b0};
        vecs[6]  = '{4'd9,  20'h00052, 8'h52, 8'h52, 1'b0, 1'b0};
        vecs[7]  = '{4'd9,  20'h00061, 8'h61, 8'h61, 1'b0, 1'b0};
        vecs[8]  = '{4'd9,  20'h00070, 8'h70, 8'h70, 1'b0, 1'b0};
        vecs[9]  = '{4'd9,  20'h00079, 8'h79, 8'h79, 1'b0, 1'b0};
        vecs[10] = '{4'd9,  20'h00088, 8'h88, 8'h88, 1'b0, 1'b0};
        vecs[11] = '{4'd9,  20'h00097, 8'h97, 8'h97, 1'b0, 1'b0};
        vecs[12] = '{4'd5,  20'h00102, 8'h99, 8'h02, 1'b1, 1'b1};
        vecs[13] = '{4'd9,  20'h00111, 8'h99, 8'h11, 1'b1, 1'b1};

        rst_n = 1'b0; add_valid = 1'b0; add_amount = '0; clear = 1'b0; frame_start = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Add 7 from reset: ready low N+1 cycles, display waits for the frame pulse.
        add_req(4'd7);
        for (int i = 0; i < 4; i++) check($sformatf("t1 latency[%0d]", i), lat[i], mlat[i]);
        check_all("t1 before frame");
        frame();
        check_all("t1 after frame");

        do_clear();
        for (int v = 0; v < 14; v++) begin
            add_req(vecs[v].amt);
            check($sformatf("vec%0d sc5s", v), 32'(sc5s), 32'(vecs[v].exp5));
            check($sformatf("vec%0d sc5w", v), 32'(sc5w), 32'(vecs[v].exp5));
            check($sformatf("vec%0d sc2s", v), 32'(sc2s), 32'(vecs[v].exp2s));
            check($sformatf("vec%0d sc2w", v), 32'(sc2w), 32'(vecs[v].exp2w));
            check($sformatf("vec%0d ov2s", v), 32'(ov2s), 32'(vecs[v].ov2s));
            check($sformatf("vec%0d ov2w", v), 32'(ov2w), 32'(vecs[v].ov2w));
            check($sformatf("vec%0d ov5", v), 32'({ov5s, ov5w}), 32'd0);
        end

        // 95 + 8 -> 103 with a carry rippling through two digits.
        do_clear();
        repeat (10) add_req(4'd9);
        add_req(4'd5);
        frame();
        add_req(4'd8);
        check("t2 score 103", 32'(sc5s), 32'h00103);
        check_all("t2 before frame");
        frame();
        check_all("t2 after frame");

        // Top-digit overflow on the 2-digit pair: 98 + 5.
        do_clear();
        repeat (10) add_req(4'd9);
        add_req(4'd8);
        add_req(4'd5);
        check("t3 sat value", 32'(sc2s), 32'h99);
        check("t3 sat ovf", 32'(ov2s), 32'd1);
        check("t3 wrap value", 32'(sc2w), 32'h03);
        check("t3 wrap ovf", 32'(ov2w), 32'd1);
        check_all("t3");

        // Clear two cycles into an add of 9 on 41.
        do_clear();
        repeat (4) add_req(4'd9);
        add_req(4'd5);
        check("t4 start 41", 32'(sc5s), 32'h00041);
        add_valid = 1'b1; add_amount = 4'd9;
        @(negedge clk);
        add_valid = 1'b0;
        @(negedge clk);
        do_clear();
        check_all("t4 after clear");
        repeat (8) @(negedge clk);
        check_all("t4 settled");

        // Request in the same cycle as clear must not be taken.
        add_valid = 1'b1; add_amount = 4'd3; clear = 1'b1;
        @(negedge clk);
        add_valid = 1'b0; clear = 1'b0;
        check_all("t4b clear+valid");
        repeat (8) @(negedge clk);
        check_all("t4b settled");

        // Frame pulse coincident with the 5-digit COMMIT: 10 + 5.
        add_req(4'd9);
        add_req(4'd1);
        frame();
        check_all("t5 base");
        add_valid = 1'b1; add_amount = 4'd5;
        @(negedge clk);
        add_valid = 1'b0;
        repeat (5) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_ready("t5");
        model_add(4'd5);
        mdisp[0] = 10; mdisp[1] = 10; mdisp[2] = 15; mdisp[3] = 15;
        check_all("t5 commit frame");
        frame();
        check_all("t5 next frame");

        // add_valid held high: 20 handshakes on the 5-digit block, one per N+2 cycles.
        do_clear();
        hs = 0; cyc = 0;
        add_valid = 1'b1; add_amount = 4'd1;
        while (hs < 20 && cyc < 1000) begin
            if (rd5s) hs++;
            if (hs < 20) begin
                @(negedge clk);
                cyc++;
            end
        end
        @(negedge clk);
        add_valid = 1'b0;
        check("t6 handshake spacing", 32'(cyc), 32'd133);
        wait_ready("t6");
        mscore[0] = 20; mscore[1] = 20; mscore[2] = 34; mscore[3] = 34;
        check("t6 score 20", 32'(sc5s), 32'h00020);
        check_all("t6");
        add_req(4'd15);
        check("t6 amount 15 as 9", 32'(sc5s), 32'h00029);
        check_all("t6 amt15");

        // Async reset in the middle of an add.
        frame();
        add_valid = 1'b1; add_amount = 4'd4;
        @(negedge clk);
        add_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_all("after async reset");

        // Random traffic against the model.
        for (int k = 0; k < 200; k++) begin
            op = int'($urandom_range(0, 19));
            if (op < 14) add_req(4'($urandom_range(0, 15)));
            else if (op < 18) frame();
            else if (op < 19) do_clear();
            else @(negedge clk);
            check_all($sformatf("rand%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
